// File: rtl/jsc_ensemble_vote_pkg.sv
// Shared constants, FSM state type and width helper for the ensemble vote block.
package jsc_ensemble_pkg;

  localparam int NUM_CLASSES = 5;
  localparam int ACT_W       = 2;
  localparam int NUM_MEMBERS = 4;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    ARGMAX = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // Ceiling log2, returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/jsc_ensemble_vote_if.sv
// Beat input and result output handshakes of the ensemble vote block.
interface jsc_ensemble_vote_if
  import jsc_ensemble_pkg::*;
#(
  parameter int NUM_CLASSES = jsc_ensemble_pkg::NUM_CLASSES,
  parameter int ACT_W       = jsc_ensemble_pkg::ACT_W,
  parameter int NUM_MEMBERS = jsc_ensemble_pkg::NUM_MEMBERS,
  parameter int SUM_W       = ACT_W + clog2(NUM_MEMBERS),
  parameter int IDX_W       = clog2(NUM_CLASSES)
);
  logic                           in_valid;
  logic                           in_ready;
  logic [NUM_CLASSES*ACT_W-1:0]   in_data;
  logic                           out_valid;
  logic                           out_ready;
  logic [IDX_W-1:0]               out_class;
  logic [SUM_W-1:0]               out_score;

  // Producer of beats and consumer of results.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_class, out_score
  );

  // The vote block itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_class, out_score
  );
endinterface

// File: rtl/jsc_ensemble_vote_argmax.sv
// Serial argmax over the class accumulators plus the registered result.
module jsc_vote_argmax
  import jsc_ensemble_pkg::*;
#(
  parameter int NUM_CLASSES = jsc_ensemble_pkg::NUM_CLASSES,
  parameter int SUM_W       = jsc_ensemble_pkg::ACT_W + clog2(jsc_ensemble_pkg::NUM_MEMBERS),
  parameter int IDX_W       = clog2(NUM_CLASSES)
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             ack_i,
  input  logic [SUM_W-1:0] acc_i [NUM_CLASSES],
  output logic             done_o,
  output logic             out_valid_o,
  output logic [IDX_W-1:0] out_class_o,
  output logic [SUM_W-1:0] out_score_o
);
  logic             busy_q;
  logic             fin_q;
  logic [IDX_W-1:0] scan_q;
  logic [IDX_W-1:0] best_idx_q;
  logic [SUM_W-1:0] best_q;
  logic [SUM_W-1:0] cand;

  assign cand        = acc_i[scan_q];
  assign done_o      = fin_q;

  // Scan one class per cycle; strict '>' keeps the lowest index on ties.
  // The result is captured one cycle after the last compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= 1'b0;
      fin_q       <= 1'b0;
      scan_q      <= '0;
      best_idx_q  <= '0;
      best_q      <= '0;
      out_valid_o <= 1'b0;
      out_class_o <= '0;
      out_score_o <= '0;
    end else begin
      fin_q <= 1'b0;
      if (start_i) begin
        busy_q     <= 1'b1;
        scan_q     <= '0;
        best_idx_q <= '0;
        best_q     <= '0;
      end else if (busy_q) begin
        if (cand > best_q) begin
          best_q     <= cand;
          best_idx_q <= scan_q;
        end
        if (scan_q == IDX_W'(NUM_CLASSES - 1)) begin
          busy_q <= 1'b0;
          fin_q  <= 1'b1;
        end else begin
          scan_q <= scan_q + IDX_W'(1);
        end
      end
      if (fin_q) begin
        out_valid_o <= 1'b1;
        out_class_o <= best_idx_q;
        out_score_o <= best_q;
      end else if (ack_i) begin
        out_valid_o <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/jsc_ensemble_vote.sv
// Ensemble vote: accumulates per-class scores over NUM_MEMBERS beats,
// then reports the argmax class and its summed score.
module jsc_ensemble_vote
  import jsc_ensemble_pkg::*;
#(
  parameter int NUM_CLASSES = jsc_ensemble_pkg::NUM_CLASSES,
  parameter int ACT_W       = jsc_ensemble_pkg::ACT_W,
  parameter int NUM_MEMBERS = jsc_ensemble_pkg::NUM_MEMBERS,
  parameter int SUM_W       = ACT_W + clog2(NUM_MEMBERS),
  parameter int IDX_W       = clog2(NUM_CLASSES)
)(
  input  logic                clk,
  input  logic                rst_n,
  jsc_ensemble_vote_if.slave  bus
);
  localparam int MCNT_W = (NUM_MEMBERS > 1) ? clog2(NUM_MEMBERS) : 1;

  state_t            state_q, state_d;
  logic              live_q;
  logic [MCNT_W-1:0] mcnt_q, mcnt_d;
  logic [SUM_W-1:0]  acc_q [NUM_CLASSES];
  logic [SUM_W-1:0]  acc_d [NUM_CLASSES];
  logic              in_ready_w;
  logic              accept;
  logic              last_beat;
  logic              out_ack;
  logic              scan_done;
  logic              out_valid_w;

  assign in_ready_w   = live_q && (state_q == ACCUM);
  assign accept       = bus.in_valid && in_ready_w;
  assign last_beat    = accept && (mcnt_q == MCNT_W'(NUM_MEMBERS - 1));
  assign out_ack      = (state_q == HOLD) && out_valid_w && bus.out_ready;
  assign bus.in_ready = in_ready_w;
  assign bus.out_valid = out_valid_w;

  // Phase register; live_q keeps in_ready low until the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
    end
  end

  // Next phase: ACCUM -> ARGMAX on the last beat, -> HOLD when the scan ends,
  // back to ACCUM once the consumer takes the result.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM:   if (last_beat) state_d = ARGMAX;
      ARGMAX:  if (scan_done) state_d = HOLD;
      HOLD:    if (out_ack)   state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // Accumulator and member-count next state: add zero-extended slices per beat,
  // clear when the result is handed off.
  always_comb begin
    acc_d  = acc_q;
    mcnt_d = mcnt_q;
    if (out_ack) begin
      for (int c = 0; c < NUM_CLASSES; c++) acc_d[c] = '0;
      mcnt_d = '0;
    end else if (accept) begin
      for (int c = 0; c < NUM_CLASSES; c++) begin
        acc_d[c] = acc_q[c] + SUM_W'(bus.in_data[c*ACT_W +: ACT_W]);
      end
      mcnt_d = last_beat ? '0 : mcnt_q + MCNT_W'(1);
    end
  end

  // Accumulator and member-count registers; reset discards partial sums.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CLASSES; c++) acc_q[c] <= '0;
      mcnt_q <= '0;
    end else begin
      acc_q  <= acc_d;
      mcnt_q <= mcnt_d;
    end
  end

  jsc_vote_argmax #(
    .NUM_CLASSES (NUM_CLASSES),
    .SUM_W       (SUM_W),
    .IDX_W       (IDX_W)
  ) u_argmax (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (last_beat),
    .ack_i       (out_ack),
    .acc_i       (acc_q),
    .done_o      (scan_done),
    .out_valid_o (out_valid_w),
    .out_class_o (bus.out_class),
    .out_score_o (bus.out_score)
  );
endmodule
